// File: rtl/emio_ctrl_filter.sv
// emio_ctrl_filter: resynchronises PS7 EMIO GPIO control bits into the fabric
// clock domain, deglitches each bit with a per-bit stability counter, emits
// clean levels with one-cycle rise/fall strobes, and returns the filtered
// levels plus a saturating transition count for PS readback.
module emio_ctrl_filter #(
  parameter int unsigned       WIDTH         = 2,
  parameter int unsigned       SYNC_STAGES   = 2,
  parameter int unsigned       STABLE_CYCLES = 4,
  parameter logic [WIDTH-1:0]  INIT_VAL      = {WIDTH{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   gpio_raw,
  input  logic               count_clr,
  output logic [WIDTH-1:0]   ctrl_out,
  output logic [WIDTH-1:0]   ctrl_rise,
  output logic [WIDTH-1:0]   ctrl_fall,
  output logic [7:0]         change_count,
  output logic [WIDTH+7:0]   gpio_readback
);

  // Stability counter sized to hold 0..STABLE_CYCLES; acceptance happens
  // when the counter has already seen STABLE_CYCLES-1 differing cycles.
  localparam int unsigned    CW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  synced_s;

  logic [CW-1:0]    stab_q [WIDTH];
  logic [CW-1:0]    stab_d [WIDTH];
  logic [WIDTH-1:0] ctrl_q, ctrl_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [7:0]       count_q, count_d;
  logic             accept_s;

  assign synced_s = sync_q[SYNC_STAGES-1];

  // Plain flop chain for metastability settling; nothing between stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{INIT_VAL}};
    end else begin
      sync_q[0] <= gpio_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Per-bit IDLE/PENDING deglitch: count cycles the synced value differs
  // from the accepted level; any return to the accepted level restarts.
  always_comb begin
    ctrl_d = ctrl_q;
    rise_d = {WIDTH{1'b0}};
    fall_d = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      stab_d[i] = stab_q[i];
      if (synced_s[i] == ctrl_q[i]) begin
        stab_d[i] = {CW{1'b0}};
      end else if (stab_q[i] == LAST) begin
        ctrl_d[i] = synced_s[i];
        stab_d[i] = {CW{1'b0}};
        rise_d[i] = synced_s[i];
        fall_d[i] = ~synced_s[i];
      end else begin
        stab_d[i] = stab_q[i] + ONE;
      end
    end
  end

  assign accept_s = |(rise_d | fall_d);

  // Transition counter: one step per accepting cycle, saturating; clear wins.
  always_comb begin
    count_d = count_q;
    if (count_clr) begin
      count_d = 8'd0;
    end else if (accept_s && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Filter state, strobes and counter registers; reset drops any pending change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= INIT_VAL;
      rise_q  <= {WIDTH{1'b0}};
      fall_q  <= {WIDTH{1'b0}};
      count_q <= 8'd0;
      for (int i = 0; i < WIDTH; i++) begin
        stab_q[i] <= {CW{1'b0}};
      end
    end else begin
      ctrl_q  <= ctrl_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
      for (int i = 0; i < WIDTH; i++) begin
        stab_q[i] <= stab_d[i];
      end
    end
  end

  assign ctrl_out      = ctrl_q;
  assign ctrl_rise     = rise_q;
  assign ctrl_fall     = fall_q;
  assign change_count  = count_q;
  assign gpio_readback = {count_q, ctrl_q};

endmodule

// File: tb/tb_emio_ctrl_filter.sv
// Directed self-checking bench for emio_ctrl_filter (default parameters).
module tb_emio_ctrl_filter;

  logic       clk;
  logic       rst;
  logic [1:0] gpio_raw;
  logic       count_clr;
  logic [1:0] ctrl_out;
  logic [1:0] ctrl_rise;
  logic [1:0] ctrl_fall;
  logic [7:0] change_count;
  logic [9:0] gpio_readback;

  int errors = 0;
  int checks = 0;

  emio_ctrl_filter dut (
    .clk           (clk),
    .rst           (rst),
    .gpio_raw      (gpio_raw),
    .count_clr     (count_clr),
    .ctrl_out      (ctrl_out),
    .ctrl_rise     (ctrl_rise),
    .ctrl_fall     (ctrl_fall),
    .change_count  (change_count),
    .gpio_readback (gpio_readback)
  );

  // 10 ns fabric clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; gpio_raw = 2'b11; count_clr = 1'b0;
    #1;
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (ctrl_out !== 2'b00 || ctrl_rise !== 2'b00 || ctrl_fall !== 2'b00 ||
          change_count !== 8'd0 || gpio_readback !== 10'h000) begin
        errors++;
        $display("FAIL reset cyc%0d: out=%b rise=%b fall=%b cnt=%0d rb=%h, want 00 00 00 0 000",
                 n, ctrl_out, ctrl_rise, ctrl_fall, change_count, gpio_readback);
      end
      tick();
    end
    gpio_raw = 2'b00;
    rst = 1'b0;
    for (int n = 0; n < 8; n++) tick();
    checks++;
    if (ctrl_out !== 2'b00 || change_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_release: out=%b cnt=%0d, want 00 0", ctrl_out, change_count);
    end
  endtask

  // 00->01 sampled at edge 0 appears after edge 5 with a one-cycle rise strobe.
  task automatic test_clean_step();
    gpio_raw = 2'b01;
    tick(); // edge 0
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (ctrl_out !== 2'b00 || ctrl_rise !== 2'b00) begin
        errors++;
        $display("FAIL step_early e%0d: out=%b rise=%b, want 00 00", e, ctrl_out, ctrl_rise);
      end
    end
    tick(); // edge 5
    checks++;
    if (ctrl_out !== 2'b01 || ctrl_rise !== 2'b01 || ctrl_fall !== 2'b00 ||
        change_count !== 8'd1 || gpio_readback !== 10'h005) begin
      errors++;
      $display("FAIL step_accept: out=%b rise=%b fall=%b cnt=%0d rb=%h, want 01 01 00 1 005",
               ctrl_out, ctrl_rise, ctrl_fall, change_count, gpio_readback);
    end
    tick();
    checks++;
    if (ctrl_out !== 2'b01 || ctrl_rise !== 2'b00 || change_count !== 8'd1) begin
      errors++;
      $display("FAIL step_after: out=%b rise=%b cnt=%0d, want 01 00 1", ctrl_out, ctrl_rise, change_count);
    end
  endtask

  // 3-cycle pulse on bit 1 is rejected; a 4-cycle pulse is accepted then falls back.
  task automatic test_glitch();
    gpio_raw = 2'b11;
    for (int n = 0; n < 3; n++) tick();
    gpio_raw = 2'b01;
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if (ctrl_out !== 2'b01 || ctrl_rise !== 2'b00 || ctrl_fall !== 2'b00 || change_count !== 8'd1) begin
        errors++;
        $display("FAIL glitch3 c%0d: out=%b rise=%b fall=%b cnt=%0d, want 01 00 00 1",
                 n, ctrl_out, ctrl_rise, ctrl_fall, change_count);
      end
    end
    gpio_raw = 2'b11;
    tick(); // edge 0
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (ctrl_out !== 2'b01) begin
        errors++;
        $display("FAIL glitch4_hold e%0d: out=%b, want 01", e, ctrl_out);
      end
    end
    gpio_raw = 2'b01;
    tick(); // edge 4
    checks++;
    if (ctrl_out !== 2'b01 || ctrl_rise !== 2'b00) begin
      errors++;
      $display("FAIL glitch4_e4: out=%b rise=%b, want 01 00", ctrl_out, ctrl_rise);
    end
    tick(); // edge 5
    checks++;
    if (ctrl_out !== 2'b11 || ctrl_rise !== 2'b10 || change_count !== 8'd2) begin
      errors++;
      $display("FAIL glitch4_rise: out=%b rise=%b cnt=%0d, want 11 10 2", ctrl_out, ctrl_rise, change_count);
    end
    for (int e = 6; e <= 8; e++) begin
      tick();
      checks++;
      if (ctrl_out !== 2'b11 || ctrl_rise !== 2'b00 || ctrl_fall !== 2'b00) begin
        errors++;
        $display("FAIL glitch4_mid e%0d: out=%b rise=%b fall=%b, want 11 00 00", e, ctrl_out, ctrl_rise, ctrl_fall);
      end
    end
    tick(); // edge 9
    checks++;
    if (ctrl_out !== 2'b01 || ctrl_fall !== 2'b10 || change_count !== 8'd3) begin
      errors++;
      $display("FAIL glitch4_fall: out=%b fall=%b cnt=%0d, want 01 10 3", ctrl_out, ctrl_fall, change_count);
    end
  endtask

  // Both bits change together: one combined strobe, one count step.
  task automatic test_simultaneous();
    gpio_raw = 2'b00;
    for (int n = 0; n < 8; n++) tick();
    checks++;
    if (ctrl_out !== 2'b00 || change_count !== 8'd4) begin
      errors++;
      $display("FAIL simul_prep: out=%b cnt=%0d, want 00 4", ctrl_out, change_count);
    end
    gpio_raw = 2'b11;
    for (int n = 0; n < 5; n++) tick(); // edges 0..4
    tick(); // edge 5
    checks++;
    if (ctrl_out !== 2'b11 || ctrl_rise !== 2'b11 || ctrl_fall !== 2'b00 || change_count !== 8'd5) begin
      errors++;
      $display("FAIL simul_rise: out=%b rise=%b fall=%b cnt=%0d, want 11 11 00 5",
               ctrl_out, ctrl_rise, ctrl_fall, change_count);
    end
    tick();
    checks++;
    if (ctrl_rise !== 2'b00 || change_count !== 8'd5) begin
      errors++;
      $display("FAIL simul_rise_after: rise=%b cnt=%0d, want 00 5", ctrl_rise, change_count);
    end
    gpio_raw = 2'b00;
    for (int n = 0; n < 6; n++) tick(); // edges 0..5
    checks++;
    if (ctrl_out !== 2'b00 || ctrl_fall !== 2'b11 || ctrl_rise !== 2'b00 || change_count !== 8'd6) begin
      errors++;
      $display("FAIL simul_fall: out=%b fall=%b rise=%b cnt=%0d, want 00 11 00 6",
               ctrl_out, ctrl_fall, ctrl_rise, change_count);
    end
    tick();
  endtask

  // 300 clean toggles saturate the count at 255; clear beats a coincident accept.
  task automatic test_saturation_clear();
    for (int t = 1; t <= 300; t++) begin
      gpio_raw = {1'b0, ~gpio_raw[0]};
      for (int n = 0; n < 7; n++) tick();
      if (t == 200) begin
        checks++;
        if (change_count !== 8'd206) begin
          errors++;
          $display("FAIL count_200: cnt=%0d, want 206", change_count);
        end
      end
    end
    checks++;
    if (change_count !== 8'd255 || ctrl_out !== 2'b00) begin
      errors++;
      $display("FAIL count_sat: cnt=%0d out=%b, want 255 00", change_count, ctrl_out);
    end
    gpio_raw = 2'b01;
    for (int n = 0; n < 5; n++) tick(); // edges 0..4
    count_clr = 1'b1;
    tick(); // edge 5: accept and clear together
    count_clr = 1'b0;
    checks++;
    if (change_count !== 8'd0 || ctrl_out !== 2'b01 || ctrl_rise !== 2'b01) begin
      errors++;
      $display("FAIL clr_prio: cnt=%0d out=%b rise=%b, want 0 01 01", change_count, ctrl_out, ctrl_rise);
    end
    tick();
    checks++;
    if (change_count !== 8'd0) begin
      errors++;
      $display("FAIL clr_hold: cnt=%0d, want 0", change_count);
    end
    gpio_raw = 2'b00;
    for (int n = 0; n < 7; n++) tick();
    checks++;
    if (change_count !== 8'd1 || ctrl_out !== 2'b00) begin
      errors++;
      $display("FAIL clr_restart: cnt=%0d out=%b, want 1 00", change_count, ctrl_out);
    end
  endtask

  // Reset while bit 0 is pending discards it; requalification starts from zero.
  task automatic test_reset_mid();
    gpio_raw = 2'b01;
    for (int n = 0; n < 4; n++) tick(); // edges 0..3, counter at 2
    rst = 1'b1;
    #1;
    checks++;
    if (ctrl_out !== 2'b00 || change_count !== 8'd0 || gpio_readback !== 10'h000 ||
        ctrl_rise !== 2'b00 || ctrl_fall !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid: out=%b cnt=%0d rb=%h, want 00 0 000", ctrl_out, change_count, gpio_readback);
    end
    tick();
    tick();
    rst = 1'b0;
    tick(); // edge 0 after release
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (ctrl_out !== 2'b00) begin
        errors++;
        $display("FAIL rst_requal e%0d: out=%b, want 00", e, ctrl_out);
      end
    end
    tick(); // edge 5
    checks++;
    if (ctrl_out !== 2'b01 || ctrl_rise !== 2'b01 || change_count !== 8'd1) begin
      errors++;
      $display("FAIL rst_accept: out=%b rise=%b cnt=%0d, want 01 01 1", ctrl_out, ctrl_rise, change_count);
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_simultaneous();
    test_saturation_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/emio_ctrl_filter.md
Name: emio_ctrl_filter

Overview:
Upstream conditioning stage between the PS7 EMIO GPIO outputs and the fabric counter/LED logic. It resynchronises PS-driven control bits into the fabric clock domain and deglitches each bit with a per-bit stability counter. It emits clean levels plus single-cycle rise/fall strobes that drive the counter's enable and direction, and returns the filtered levels and a transition count to the PS on EMIO GPIO inputs for readback.

Parameters:
WIDTH, 2, number of control bits filtered (bit 0 = count enable, bit 1 = count direction in the default build); legal 1..32
SYNC_STAGES, 2, synchroniser flops per bit; legal 2..4
STABLE_CYCLES, 4, consecutive cycles a new synced value must persist before acceptance; legal 1..65535, 0 illegal
INIT_VAL, {WIDTH{1'b0}}, reset value of synchroniser flops and ctrl_out

Ports:
clk  in  1  fabric clock (BUFG output)
rst  in  1  asynchronous, active-high reset
gpio_raw  in  WIDTH  EMIO GPIO output bits from PS7, asynchronous to clk
count_clr  in  1  synchronous clear of change_count, from a PS GPIO bit already synced by the caller
ctrl_out  out  WIDTH  filtered control levels
ctrl_rise  out  WIDTH  one-cycle strobe per bit on accepted 0->1
ctrl_fall  out  WIDTH  one-cycle strobe per bit on accepted 1->0
change_count  out  8  saturating count of cycles with at least one accepted transition
gpio_readback  out  WIDTH+8  {change_count, ctrl_out} for EMIO GPIO inputs

Behaviour:
- Reset (async assert, release synchronous to clk): sync flops = INIT_VAL, ctrl_out = INIT_VAL, stability counters = 0, ctrl_rise = ctrl_fall = 0, change_count = 0.
- Synchroniser: per bit, SYNC_STAGES-deep flop chain; the last stage is the sampled value s[i]. No logic between stages.
- Stability counter per bit, width clog2(STABLE_CYCLES+1):
  - s[i] == ctrl_out[i]: counter <= 0.
  - s[i] != ctrl_out[i] and counter < STABLE_CYCLES-1: counter <= counter+1.
  - s[i] != ctrl_out[i] and counter == STABLE_CYCLES-1: ctrl_out[i] <= s[i], counter <= 0, and the matching strobe registers high for exactly the next cycle.
- Per-bit two-state view: IDLE (s == out, counter 0) and PENDING (s != out, counting). Any return of s to out in PENDING drops to IDLE with counter 0. A glitch shorter than STABLE_CYCLES never reaches ctrl_out.
- Latency: a clean level change sampled at clk edge 0 appears on ctrl_out after SYNC_STAGES+STABLE_CYCLES-1 further edges. Strobes are coincident with the first cycle ctrl_out shows the new value.
- STABLE_CYCLES = 1: acceptance occurs on the first cycle s differs, with no filtering beyond synchronisation.
- Bits are fully independent. Simultaneous acceptance on several bits in one cycle raises all relevant strobes together.
- change_count:
  - +1 in any cycle where one or more bits are accepted, regardless of how many bits change.
  - Saturates at 255 and holds.
  - count_clr = 1 forces 0 on the next edge and takes priority over a simultaneous increment.
- gpio_readback is purely the concatenation of registered outputs, with no additional latency.
- Reset mid-PENDING: pending change discarded and outputs return to INIT_VAL immediately. After release, a still-different input must requalify from zero.
- No X propagation: all outputs are defined from reset onward.

Test Plan:
(Defaults: WIDTH=2, SYNC_STAGES=2, STABLE_CYCLES=4, INIT_VAL=0.)
- Reset: hold rst with gpio_raw=2'b11 -> ctrl_out=00, strobes 0, change_count=0, gpio_readback=10'h000 throughout reset.
- Clean step: gpio_raw 00->01 at edge 0 and held -> ctrl_out[0]=1 after edge 5, ctrl_rise=01 for exactly that one cycle, change_count=1.
- Glitch reject: gpio_raw[1] high for 3 cycles then low -> ctrl_out stays 00, no strobes, change_count unchanged. Repeat with 4 cycles -> accepted, ctrl_rise=10 pulse.
- Simultaneous: both bits 00->11 on the same edge -> ctrl_rise=11 in one cycle, change_count +1 only. Then 11->00 -> ctrl_fall=11, count +1.
- Saturation/clear: toggle bit 0 cleanly 300 times -> change_count=255 held. Assert count_clr on a cycle that also accepts a change -> change_count=0.
- Reset mid-operation: assert rst two cycles into PENDING on bit 0 -> ctrl_out=00 immediately. Release with input still 1 -> acceptance requires the full SYNC_STAGES+STABLE_CYCLES-1 edges again.
